// File: rtl/dcpirq_pkg.sv
// Shared types and helpers for the dcpirq interrupt controller.
package dcpirq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; used to size channel indices.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dcpirq_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module dcpirq_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/dcpirq_param.sv
// Parameterised interrupt controller: edge/level capture, fixed priority, one-cycle gap.
module dcpirq_param
  import dcpirq_pkg::*;
#(
  parameter int               N_IRQ     = 8,
  parameter logic [N_IRQ-1:0] TRIG_EDGE = '1,
  localparam int              ADDR_W    = clog2(N_IRQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_IRQ-1:0]  irq_trigger,
  input  logic [N_IRQ-1:0]  irq_mask,
  input  logic              irq_ack,
  output logic              int_output,
  output logic [ADDR_W-1:0] irq_address,
  output logic [N_IRQ-1:0]  pending
);

  state_t             state;
  logic [N_IRQ-1:0]   trig_q;
  logic [N_IRQ-1:0]   detect;
  logic [N_IRQ-1:0]   ack_clr;
  logic [N_IRQ-1:0]   req;
  logic [ADDR_W-1:0]  enc_idx;
  logic               enc_valid;

  // Level channels ignore trig_q; edge channels need a low-to-high step.
  assign detect = irq_trigger & (~trig_q | ~TRIG_EDGE);
  assign req    = pending & irq_mask;

  always_comb begin
    ack_clr = '0;
    if (state == ASSERT && irq_ack) ack_clr[irq_address] = 1'b1;
  end

  dcpirq_prio_enc #(
    .N (N_IRQ),
    .W (ADDR_W)
  ) u_prio_enc (
    .req   (req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trig_q      <= '0;
      pending     <= '0;
      int_output  <= 1'b0;
      irq_address <= '0;
    end else begin
      trig_q  <= irq_trigger;
      // A new detection outranks an acknowledge clearing the same bit.
      pending <= (pending & ~ack_clr) | detect;
      unique case (state)
        IDLE: begin
          if (enable && enc_valid) begin
            irq_address <= enc_idx;
            int_output  <= 1'b1;
            state       <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            int_output <= 1'b0;
            state      <= GAP;
          end else if (!enable) begin
            int_output <= 1'b0;
            state      <= IDLE;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          int_output <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcpirq_param.sv
// Bench for dcpirq_param: edge-mode and level-mode instances against a behavioural model.
module tb_dcpirq_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       irq_ack;
  logic [7:0] irq_trigger;
  logic [7:0] irq_mask;

  logic       e_int, l_int;
  logic [2:0] e_addr, l_addr;
  logic [7:0] e_pend, l_pend;

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = edge instance, 1 = level instance.
  logic [7:0] m_tq[2];
  logic [7:0] m_pend[2];
  logic       m_int[2];
  logic [2:0] m_addr[2];
  logic       m_gap[2];

  always #5 clk = ~clk;

  dcpirq_param #(.N_IRQ(8), .TRIG_EDGE(8'hFF)) dut_e (
    .clk(clk), .rst(rst), .enable(enable), .irq_trigger(irq_trigger),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .int_output(e_int),
    .irq_address(e_addr), .pending(e_pend)
  );

  dcpirq_param #(.N_IRQ(8), .TRIG_EDGE(8'h00)) dut_l (
    .clk(clk), .rst(rst), .enable(enable), .irq_trigger(irq_trigger),
    .irq_mask(irq_mask), .irq_ack(irq_ack), .int_output(l_int),
    .irq_address(l_addr), .pending(l_pend)
  );

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    logic [7:0] det, clr;
    for (int v = 0; v < 2; v++) begin
      if (rst) begin
        m_tq[v] = 0; m_pend[v] = 0; m_int[v] = 0; m_addr[v] = 0; m_gap[v] = 0;
      end else begin
        det = 0;
        clr = 0;
        for (int i = 0; i < 8; i++)
          if (irq_trigger[i] && (v == 1 || !m_tq[v][i])) det[i] = 1'b1;
        if (m_int[v]) begin
          if (irq_ack) begin
            clr[m_addr[v]] = 1'b1;
            m_int[v] = 0;
            m_gap[v] = 1;
          end else if (!enable) begin
            m_int[v] = 0;
          end
        end else if (m_gap[v]) begin
          m_gap[v] = 0;
        end else if (enable) begin
          for (int i = 7; i >= 0; i--)
            if (m_pend[v][i] && irq_mask[i]) begin
              m_addr[v] = 3'(i);
              m_int[v]  = 1;
            end
        end
        m_pend[v] = (m_pend[v] & ~clr) | det;
        m_tq[v]   = irq_trigger;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; irq_trigger = 0; irq_ack = 0; enable = 1; irq_mask = 8'hFF;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; irq_trigger = 0; irq_ack = 0; enable = 1; irq_mask = 8'hFF;
    tick(); tick();
    rst = 0;
    tick();
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL reset_int got=%0b exp=0", e_int); end
    total++; if (e_pend !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h exp=00", e_pend); end
    total++; if (e_addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", e_addr); end
    total++; if (l_pend !== 8'h00) begin bad++; $display("FAIL reset_pend_lvl got=%h exp=00", l_pend); end
  endtask

  task automatic test_single_edge();
    do_reset();
    irq_trigger = 8'h20; tick(); irq_trigger = 0;
    total++; if (e_pend !== 8'h20) begin bad++; $display("FAIL single_pend got=%h exp=20", e_pend); end
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", e_int); end
    tick();
    total++; if (e_int !== 1'b1) begin bad++; $display("FAIL single_int got=%0b exp=1", e_int); end
    total++; if (e_addr !== 3'd5) begin bad++; $display("FAIL single_addr got=%0d exp=5", e_addr); end
    irq_ack = 1; tick(); irq_ack = 0;
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL single_ack_int got=%0b exp=0", e_int); end
    total++; if (e_pend !== 8'h00) begin bad++; $display("FAIL single_ack_pend got=%h exp=00", e_pend); end
    irq_ack = 1; tick(); irq_ack = 0;
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL single_gap got=%0b exp=0", e_int); end
  endtask

  task automatic test_priority();
    do_reset();
    irq_trigger = 8'h44; tick(); irq_trigger = 0; tick();
    total++; if (e_int !== 1'b1 || e_addr !== 3'd2) begin bad++; $display("FAIL prio_first got=%0b/%0d exp=1/2", e_int, e_addr); end
    irq_trigger = 8'h01; tick(); irq_trigger = 0;
    total++; if (e_addr !== 3'd2) begin bad++; $display("FAIL prio_no_preempt got=%0d exp=2", e_addr); end
    irq_ack = 1; tick(); irq_ack = 0;
    total++; if (e_pend !== 8'h41) begin bad++; $display("FAIL prio_pend got=%h exp=41", e_pend); end
    tick();
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL prio_gap got=%0b exp=0", e_int); end
    tick();
    total++; if (e_int !== 1'b1 || e_addr !== 3'd0) begin bad++; $display("FAIL prio_second got=%0b/%0d exp=1/0", e_int, e_addr); end
    irq_ack = 1; tick(); irq_ack = 0; tick(); tick();
    total++; if (e_int !== 1'b1 || e_addr !== 3'd6) begin bad++; $display("FAIL prio_third got=%0b/%0d exp=1/6", e_int, e_addr); end
    irq_ack = 1; tick(); irq_ack = 0; tick();
  endtask

  task automatic test_mask();
    do_reset();
    irq_mask = 8'hF7; irq_trigger = 8'h08; tick(); irq_trigger = 0;
    total++; if (e_pend !== 8'h08) begin bad++; $display("FAIL mask_pend got=%h exp=08", e_pend); end
    tick(); tick();
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL mask_hold got=%0b exp=0", e_int); end
    irq_mask = 8'hFF; tick();
    total++; if (e_int !== 1'b1 || e_addr !== 3'd3) begin bad++; $display("FAIL mask_release got=%0b/%0d exp=1/3", e_int, e_addr); end
    irq_mask = 8'h00; tick();
    total++; if (e_int !== 1'b1) begin bad++; $display("FAIL mask_no_withdraw got=%0b exp=1", e_int); end
    irq_mask = 8'hFF; irq_ack = 1; tick(); irq_ack = 0; tick();
  endtask

  task automatic test_enable_drop();
    do_reset();
    irq_trigger = 8'h02; tick(); irq_trigger = 0; tick();
    total++; if (e_int !== 1'b1 || e_addr !== 3'd1) begin bad++; $display("FAIL en_first got=%0b/%0d exp=1/1", e_int, e_addr); end
    enable = 0; tick();
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL en_drop got=%0b exp=0", e_int); end
    total++; if (e_pend !== 8'h02) begin bad++; $display("FAIL en_pend got=%h exp=02", e_pend); end
    enable = 1; tick();
    total++; if (e_int !== 1'b1 || e_addr !== 3'd1) begin bad++; $display("FAIL en_again got=%0b/%0d exp=1/1", e_int, e_addr); end
    irq_ack = 1; tick(); irq_ack = 0; tick();
  endtask

  task automatic test_reset_release();
    rst = 1; irq_trigger = 8'h10; irq_ack = 0; enable = 1; irq_mask = 8'hFF;
    tick(); rst = 0; tick(); irq_trigger = 0;
    total++; if (e_pend !== 8'h10) begin bad++; $display("FAIL rel_pend got=%h exp=10", e_pend); end
    tick();
    total++; if (e_int !== 1'b1 || e_addr !== 3'd4) begin bad++; $display("FAIL rel_int got=%0b/%0d exp=1/4", e_int, e_addr); end
    irq_trigger = 8'h01; tick(); irq_trigger = 0; rst = 1; tick(); rst = 0;
    total++; if (e_int !== 1'b0 || e_pend !== 8'h00) begin bad++; $display("FAIL rst_assert got=%0b/%h exp=0/00", e_int, e_pend); end
  endtask

  task automatic test_level();
    do_reset();
    irq_trigger = 8'h01; tick();
    total++; if (l_pend !== 8'h01) begin bad++; $display("FAIL lvl_pend got=%h exp=01", l_pend); end
    tick();
    total++; if (l_int !== 1'b1 || l_addr !== 3'd0) begin bad++; $display("FAIL lvl_int got=%0b/%0d exp=1/0", l_int, l_addr); end
    irq_ack = 1; tick(); irq_ack = 0;
    total++; if (l_pend !== 8'h01) begin bad++; $display("FAIL lvl_set_wins got=%h exp=01", l_pend); end
    total++; if (e_pend !== 8'h00) begin bad++; $display("FAIL lvl_edge_clr got=%h exp=00", e_pend); end
    total++; if (l_int !== 1'b0) begin bad++; $display("FAIL lvl_gap got=%0b exp=0", l_int); end
    tick();
    total++; if (l_int !== 1'b0) begin bad++; $display("FAIL lvl_idle got=%0b exp=0", l_int); end
    tick();
    total++; if (l_int !== 1'b1 || l_addr !== 3'd0) begin bad++; $display("FAIL lvl_again got=%0b/%0d exp=1/0", l_int, l_addr); end
    total++; if (e_int !== 1'b0) begin bad++; $display("FAIL lvl_edge_once got=%0b exp=0", e_int); end
    irq_trigger = 0; irq_ack = 1; tick(); irq_ack = 0; tick();
  endtask

  task automatic test_random();
    logic       g_int;
    logic [2:0] g_addr;
    logic [7:0] g_pend;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 149) == 0);
      irq_trigger = 8'($urandom & $urandom & $urandom);
      irq_mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      enable      = ($urandom_range(0, 9) != 0);
      irq_ack     = ($urandom_range(0, 2) == 0);
      tick();
      for (int v = 0; v < 2; v++) begin
        g_int  = v ? l_int  : e_int;
        g_addr = v ? l_addr : e_addr;
        g_pend = v ? l_pend : e_pend;
        total++;
        if (g_int !== m_int[v]) begin bad++; $display("FAIL rand_int v=%0d cyc=%0d got=%0b exp=%0b", v, c, g_int, m_int[v]); end
        total++;
        if (g_pend !== m_pend[v]) begin bad++; $display("FAIL rand_pend v=%0d cyc=%0d got=%h exp=%h", v, c, g_pend, m_pend[v]); end
        if (m_int[v]) begin
          total++;
          if (g_addr !== m_addr[v]) begin bad++; $display("FAIL rand_addr v=%0d cyc=%0d got=%0d exp=%0d", v, c, g_addr, m_addr[v]); end
        end
      end
    end
    rst = 0; irq_ack = 0;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_mask();
    test_enable_drop();
    test_reset_release();
    test_level();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcpirq_param.md
DCPIRQ_PARAM -- requirements
Module: dcpirq_param

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, giving the number of interrupt channels (legal range 2..32).
REQ-002 SHALL have parameter TRIG_EDGE, N_IRQ bits, default all-ones; per channel, 1 = rising-edge trigger, 0 = level trigger.
REQ-003 SHALL have derived localparam ADDR_W = clog2(N_IRQ), not overridable.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  global enable; 1 = new interrupts may be presented.
REQ-007 irq_trigger  in  N_IRQ  interrupt request lines, synchronous to clk.
REQ-008 irq_mask  in  N_IRQ  per-channel enable; 1 = channel may be presented.
REQ-009 irq_ack  in  1  acknowledge of the currently presented interrupt.
REQ-010 int_output  out  1  registered interrupt request to the CPU.
REQ-011 irq_address  out  ADDR_W  index of the presented channel; valid while int_output=1.
REQ-012 pending  out  N_IRQ  registered pending vector, for observation.

Function
REQ-013 SHALL register irq_trigger into trig_q each cycle; edge channels detect irq_trigger=1 and trig_q=0; level channels detect irq_trigger=1.
REQ-014 A detected request in cycle k SHALL set pending[i] from cycle k+1, independent of irq_mask and enable.
REQ-015 An edge arriving on a channel whose pending bit is already set SHALL be absorbed, with no count.
REQ-016 The FSM SHALL have states IDLE, ASSERT and GAP.
REQ-017 IDLE: if enable=1 and (pending & irq_mask) is nonzero, the FSM SHALL latch the lowest set index into irq_address and enter ASSERT; int_output=1 from the next cycle.
REQ-018 Priority SHALL be fixed, with index 0 highest.
REQ-019 Latency: trigger first sampled high in cycle k gives int_output=1 in cycle k+2 when the FSM is idle.
REQ-020 ASSERT: irq_address and int_output SHALL hold stable until irq_ack=1 or enable=0.
REQ-021 ASSERT with irq_ack=1: pending[irq_address] SHALL clear, int_output SHALL go 0 next cycle, and the FSM SHALL enter GAP.
REQ-022 GAP SHALL last exactly one cycle with int_output=0, then go to IDLE, so there is at least one low cycle between interrupts.
REQ-023 ASSERT with enable=0: the FSM SHALL return to IDLE, deassert int_output next cycle, and keep pending unchanged (withdrawn, not lost).
REQ-024 Clearing irq_mask of the presented channel during ASSERT SHALL NOT withdraw it; the request is held until ack.
REQ-025 Set and ack-clear of the same pending bit in one cycle: set SHALL win, and the bit stays 1.
REQ-026 A level channel still high after ack SHALL re-pend the next cycle.
REQ-027 irq_ack in IDLE or GAP SHALL be ignored.
REQ-028 A higher-priority request arriving during ASSERT SHALL NOT preempt; it is taken in the next IDLE.

Reset
REQ-029 When rst=1 at a clk edge, state SHALL become IDLE, and int_output, irq_address, pending and trig_q SHALL all become 0.
REQ-030 Reset during ASSERT SHALL drop int_output next cycle and discard all pending bits.
REQ-031 A trigger already high at reset release SHALL be detected as an edge on the first cycle after reset, because trig_q=0.

Structure
REQ-032 Package dcpirq_pkg SHALL hold the FSM state enum (IDLE, ASSERT, GAP) and the clog2 constant function.
REQ-033 Sub-module dcpirq_prio_enc SHALL be the combinational lowest-index priority encoder (N_IRQ in, ADDR_W index plus valid out).

Verification (N_IRQ=8, TRIG_EDGE=8'hFF unless stated)
REQ-034 Reset then idle: rst=1 for 2 cycles, then triggers 0 -> int_output=0, pending=8'h00, irq_address=0.
REQ-035 Single edge on ch5, mask=8'hFF, enable=1 -> pending[5]=1 at k+1, int_output=1 with irq_address=5 at k+2; ack -> int_output=0 next cycle, one GAP cycle, pending=8'h00.
REQ-036 Simultaneous edges on ch2 and ch6 -> ch2 presented first; after ack and GAP, ch6 presented with irq_address=6.
REQ-037 Masking: mask=8'hF7, edge on ch3 -> pending[3]=1, int_output stays 0; set mask=8'hFF -> ch3 presented 1 cycle later.
REQ-038 Enable drop: ch1 presented, enable=0 -> int_output=0 next cycle, pending[1] remains 1; enable=1 -> ch1 presented again.
REQ-039 Level mode: TRIG_EDGE=8'h00, ch0 held high, ack -> ch0 presented again after the GAP cycle; same-cycle set and ack on one bit leaves pending=1.
